// File: rtl/mem_wrr_sched_pkg.sv
// Shared types and helpers for the weighted round-robin memory scheduler.
package mem_wrr_sched_pkg;

   typedef enum logic {
      IDLE,
      LOCK
   } state_e;

   localparam int unsigned DefaultWeight = 1;

   // First index at or after rr (wrapping) whose request bit is set; rr when none.
   function automatic int unsigned next_idx(input int unsigned rr,
                                            input logic [31:0] req,
                                            input int unsigned num_req);
      int unsigned idx;
      next_idx = rr;
      for (int unsigned k = num_req; k > 0; k--) begin
         idx = (rr + k - 1) % num_req;
         if (req[idx[4:0]]) begin
            next_idx = idx;
         end
      end
   endfunction

endpackage

// File: rtl/mem_wrr_rsp_fifo.sv
// Response steering FIFO: remembers which requester issued each outstanding read.
module mem_wrr_rsp_fifo #(
   parameter int unsigned Width = 2,
   parameter int unsigned Depth = 4
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             push_i,
   input  logic [Width-1:0] data_i,
   input  logic             pop_i,
   output logic             full_o,
   output logic             empty_o,
   output logic [Width-1:0] head_o
);

   localparam int unsigned PtrWidth = $clog2(Depth);

   logic [Width-1:0]  mem_q [Depth];
   logic [PtrWidth:0] wr_ptr_q;
   logic [PtrWidth:0] rd_ptr_q;
   logic              do_push;
   logic              do_pop;

   // Extra pointer bit distinguishes full from empty when the index bits match.
   assign empty_o = (wr_ptr_q == rd_ptr_q);
   assign full_o  = (wr_ptr_q[PtrWidth] != rd_ptr_q[PtrWidth]) &&
                    (wr_ptr_q[PtrWidth-1:0] == rd_ptr_q[PtrWidth-1:0]);
   assign head_o  = mem_q[rd_ptr_q[PtrWidth-1:0]];
   assign do_push = push_i & ~full_o;
   assign do_pop  = pop_i & ~empty_o;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         if (do_push) begin
            wr_ptr_q <= wr_ptr_q + 1'b1;
         end
         if (do_pop) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (do_push) begin
         mem_q[wr_ptr_q[PtrWidth-1:0]] <= data_i;
      end
   end

endmodule

// File: rtl/mem_wrr_sched.sv
// Weighted round-robin scheduler sharing one memory port between NumReq requesters,
// granting whole bursts and steering in-order read data back to the issuer.
module mem_wrr_sched
   import mem_wrr_sched_pkg::*;
#(
   parameter int unsigned NumReq         = 4,
   parameter int unsigned AddrWidth      = 16,
   parameter int unsigned DataWidth      = 32,
   parameter int unsigned WeightWidth    = 4,
   parameter int unsigned MaxBurst       = 16,
   parameter int unsigned MaxOutstanding = 4,
   localparam int unsigned IdxWidth      = $clog2(NumReq)
) (
   input  logic                          clk_i,
   input  logic                          rst_i,
   input  logic [NumReq*WeightWidth-1:0] cfg_weight_i,
   input  logic [NumReq-1:0]             req_i,
   input  logic [NumReq-1:0]             last_i,
   input  logic [NumReq-1:0]             we_i,
   input  logic [NumReq*AddrWidth-1:0]   addr_i,
   input  logic [NumReq*DataWidth-1:0]   wdata_i,
   output logic [NumReq-1:0]             gnt_o,
   output logic [NumReq-1:0]             rvalid_o,
   output logic [DataWidth-1:0]          rdata_o,
   output logic                          mem_req_o,
   input  logic                          mem_gnt_i,
   output logic                          mem_we_o,
   output logic [AddrWidth-1:0]          mem_addr_o,
   output logic [DataWidth-1:0]          mem_wdata_o,
   input  logic                          mem_rvalid_i,
   input  logic [DataWidth-1:0]          mem_rdata_i,
   output logic [IdxWidth-1:0]           owner_o,
   output logic                          busy_o,
   output logic                          err_o
);

   localparam int unsigned CntWidth = $clog2(MaxBurst + 1);

   typedef logic [IdxWidth-1:0] idx_t;

   state_e               state_q, state_d;
   idx_t                 rr_q, rr_d;
   idx_t                 owner_q, owner_d;
   idx_t                 owner;
   idx_t                 owner_inc;
   logic [WeightWidth-1:0] credit_q, credit_d;
   logic [CntWidth-1:0]  beat_cnt_q, beat_cnt_d;
   logic                 err_q, err_d;
   logic                 burst_end;

   logic                 fifo_full, fifo_empty, fifo_push, fifo_pop;
   idx_t                 fifo_head;
   logic                 accept, any_req;

   logic [WeightWidth-1:0] owner_weight, eff_weight, credit_eff;
   logic [WeightWidth:0]   credit_next;
   logic                   turn_done;

   // Outside a burst the owner is whoever is next in rotation; inside it stays pinned.
   always_comb begin
      owner = owner_q;
      if (state_q == IDLE) begin
         owner = idx_t'(next_idx(32'(rr_q), 32'(req_i), NumReq));
      end
   end

   assign any_req     = |req_i;
   assign mem_req_o   = ~fifo_full & ((state_q == IDLE) ? any_req : req_i[owner_q]);
   assign accept      = mem_req_o & mem_gnt_i;
   assign mem_we_o    = we_i[owner];
   assign mem_addr_o  = addr_i[owner*AddrWidth +: AddrWidth];
   assign mem_wdata_o = wdata_i[owner*DataWidth +: DataWidth];
   assign gnt_o       = accept ? (NumReq'(1) << owner) : '0;

   assign fifo_push   = accept & ~mem_we_o;
   assign fifo_pop    = mem_rvalid_i & ~fifo_empty;
   assign rvalid_o    = fifo_pop ? (NumReq'(1) << fifo_head) : '0;
   assign rdata_o     = mem_rdata_i;

   assign owner_o     = owner;
   assign busy_o      = (state_q == LOCK) | ~fifo_empty;
   assign err_o       = err_q;

   // Credit only carries over while the rotation pointer still sits on this owner.
   assign owner_weight = cfg_weight_i[owner*WeightWidth +: WeightWidth];
   assign eff_weight   = (owner_weight == '0) ? WeightWidth'(DefaultWeight) : owner_weight;
   assign credit_eff   = (owner == rr_q) ? credit_q : '0;
   assign credit_next  = {1'b0, credit_eff} + (WeightWidth+1)'(1);
   assign turn_done    = credit_next >= {1'b0, eff_weight};
   assign owner_inc    = (owner == idx_t'(NumReq - 1)) ? '0 : owner + 1'b1;

   always_comb begin
      state_d    = state_q;
      rr_d       = rr_q;
      credit_d   = credit_q;
      owner_d    = owner_q;
      beat_cnt_d = beat_cnt_q;
      err_d      = 1'b0;
      burst_end  = 1'b0;
      case (state_q)
         IDLE: begin
            if (accept) begin
               if (last_i[owner]) begin
                  burst_end = 1'b1;
               end else begin
                  state_d    = LOCK;
                  owner_d    = owner;
                  beat_cnt_d = CntWidth'(1);
               end
            end else if (any_req && !req_i[rr_q]) begin
               rr_d     = owner;
               credit_d = '0;
            end
         end
         LOCK: begin
            if (accept) begin
               beat_cnt_d = beat_cnt_q + 1'b1;
               if (last_i[owner_q]) begin
                  state_d    = IDLE;
                  beat_cnt_d = '0;
                  burst_end  = 1'b1;
               end else if (beat_cnt_q == CntWidth'(MaxBurst - 1)) begin
                  state_d    = IDLE;
                  beat_cnt_d = '0;
                  err_d      = 1'b1;
                  rr_d       = owner_inc;
                  credit_d   = '0;
               end
            end
         end
         default: state_d = IDLE;
      endcase
      if (burst_end) begin
         if (turn_done) begin
            rr_d     = owner_inc;
            credit_d = '0;
         end else begin
            rr_d     = owner;
            credit_d = credit_next[WeightWidth-1:0];
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= IDLE;
         rr_q       <= '0;
         owner_q    <= '0;
         credit_q   <= '0;
         beat_cnt_q <= '0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         rr_q       <= rr_d;
         owner_q    <= owner_d;
         credit_q   <= credit_d;
         beat_cnt_q <= beat_cnt_d;
         err_q      <= err_d;
      end
   end

   mem_wrr_rsp_fifo #(
      .Width (IdxWidth),
      .Depth (MaxOutstanding)
   ) u_rsp_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .push_i  (fifo_push),
      .data_i  (owner),
      .pop_i   (fifo_pop),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .head_o  (fifo_head)
   );

endmodule

// File: tb/tb_mem_wrr_sched.sv
// Scoreboard bench for mem_wrr_sched: randomized requesters and memory, checked
// against a burst/turn-level reference model.
module tb_mem_wrr_sched;

   localparam int NumReq         = 4;
   localparam int AddrWidth      = 16;
   localparam int DataWidth      = 32;
   localparam int WeightWidth    = 4;
   localparam int MaxBurst       = 16;
   localparam int MaxOutstanding = 4;
   localparam int IdxWidth       = $clog2(NumReq);
   localparam int NumCycles      = 4000;

   logic                          clk_i = 1'b0;
   logic                          rst_i = 1'b1;
   logic [NumReq*WeightWidth-1:0] cfg_weight_i = '0;
   logic [NumReq-1:0]             req_i = '0;
   logic [NumReq-1:0]             last_i = '0;
   logic [NumReq-1:0]             we_i = '0;
   logic [NumReq*AddrWidth-1:0]   addr_i = '0;
   logic [NumReq*DataWidth-1:0]   wdata_i = '0;
   logic [NumReq-1:0]             gnt_o;
   logic [NumReq-1:0]             rvalid_o;
   logic [DataWidth-1:0]          rdata_o;
   logic                          mem_req_o;
   logic                          mem_gnt_i = 1'b0;
   logic                          mem_we_o;
   logic [AddrWidth-1:0]          mem_addr_o;
   logic [DataWidth-1:0]          mem_wdata_o;
   logic                          mem_rvalid_i = 1'b0;
   logic [DataWidth-1:0]          mem_rdata_i = '0;
   logic [IdxWidth-1:0]           owner_o;
   logic                          busy_o;
   logic                          err_o;

   always #5 clk_i = ~clk_i;

   mem_wrr_sched #(
      .NumReq         (NumReq),
      .AddrWidth      (AddrWidth),
      .DataWidth      (DataWidth),
      .WeightWidth    (WeightWidth),
      .MaxBurst       (MaxBurst),
      .MaxOutstanding (MaxOutstanding)
   ) dut (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .cfg_weight_i (cfg_weight_i),
      .req_i        (req_i),
      .last_i       (last_i),
      .we_i         (we_i),
      .addr_i       (addr_i),
      .wdata_i      (wdata_i),
      .gnt_o        (gnt_o),
      .rvalid_o     (rvalid_o),
      .rdata_o      (rdata_o),
      .mem_req_o    (mem_req_o),
      .mem_gnt_i    (mem_gnt_i),
      .mem_we_o     (mem_we_o),
      .mem_addr_o   (mem_addr_o),
      .mem_wdata_o  (mem_wdata_o),
      .mem_rvalid_i (mem_rvalid_i),
      .mem_rdata_i  (mem_rdata_i),
      .owner_o      (owner_o),
      .busy_o       (busy_o),
      .err_o        (err_o)
   );

   typedef struct {
      logic [NumReq-1:0]    gnt;
      logic                 memReq;
      logic [NumReq-1:0]    rvalid;
      logic [DataWidth-1:0] rdata;
      logic                 err;
      logic                 busy;
      logic [IdxWidth-1:0]  owner;
      logic                 memWe;
      logic [AddrWidth-1:0] addr;
      logic [DataWidth-1:0] wdata;
   } exp_t;

   exp_t expQ[$];
   int   total = 0;
   int   bad   = 0;

   // Reference model: who holds the port, whose turn it is, bursts used this turn,
   // and the list of requesters awaiting read data.
   bit   mLocked = 0;
   int   mLockOwner = 0;
   int   mRr = 0;
   int   mCredit = 0;
   int   mBeats = 0;
   bit   mErr = 0;
   int   mResp[$];

   int   memDue[$];
   int   remain[NumReq];
   bit   isWr[NumReq];

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int weightOf(input int i);
      int w;
      w = int'(cfg_weight_i[i*WeightWidth +: WeightWidth]);
      return (w == 0) ? 1 : w;
   endfunction

   function automatic void modelEval(output exp_t e, output int own, output bit acc);
      bit full;
      full = (mResp.size() == MaxOutstanding);
      own  = mRr;
      if (mLocked) begin
         own = mLockOwner;
      end else begin
         for (int k = 0; k < NumReq; k++) begin
            if (req_i[(mRr + k) % NumReq]) begin
               own = (mRr + k) % NumReq;
               break;
            end
         end
      end
      e.memReq = !full && (mLocked ? req_i[own] : (req_i != '0));
      acc      = e.memReq && mem_gnt_i;
      e.gnt    = '0;
      e.gnt[own] = acc;
      e.rvalid = '0;
      if (mem_rvalid_i && mResp.size() > 0) begin
         e.rvalid[mResp[0]] = 1'b1;
      end
      e.rdata = mem_rdata_i;
      e.err   = mErr;
      e.busy  = mLocked || (mResp.size() > 0);
      e.owner = IdxWidth'(own);
      e.memWe = we_i[own];
      e.addr  = addr_i[own*AddrWidth +: AddrWidth];
      e.wdata = wdata_i[own*DataWidth +: DataWidth];
   endfunction

   task automatic endBurst(input int o);
      int used;
      used = (o == mRr) ? mCredit : 0;
      if (used + 1 >= weightOf(o)) begin
         mRr     = (o + 1) % NumReq;
         mCredit = 0;
      end else begin
         mRr     = o;
         mCredit = used + 1;
      end
   endtask

   task automatic modelUpdate(input bit acc, input int own, input bit wasRst);
      mErr = 0;
      if (wasRst) begin
         mLocked = 0;
         mRr     = 0;
         mCredit = 0;
         mBeats  = 0;
         mResp.delete();
         return;
      end
      if (mem_rvalid_i && mResp.size() > 0) void'(mResp.pop_front());
      if (acc && !we_i[own]) mResp.push_back(own);
      if (acc) begin
         if (!mLocked) begin
            if (last_i[own]) begin
               endBurst(own);
            end else begin
               mLocked    = 1;
               mLockOwner = own;
               mBeats     = 1;
            end
         end else if (last_i[own]) begin
            mLocked = 0;
            endBurst(own);
         end else if (mBeats == MaxBurst - 1) begin
            mLocked = 0;
            mRr     = (own + 1) % NumReq;
            mCredit = 0;
            mErr    = 1;
         end else begin
            mBeats++;
         end
      end else if (!mLocked && !req_i[mRr] && req_i != '0) begin
         mRr     = own;
         mCredit = 0;
      end
   endtask

   // Early cycles: every requester issues single-beat writes with an always-ready
   // memory, first with equal weights, then with requester 0 weighted 3.
   // Afterwards: random bursts (some beyond the watchdog limit), mixed reads and
   // writes, a slow in-order memory, random weights and occasional resets.
   task automatic applyStimulus(input int c);
      rst_i        = 1'b0;
      mem_rvalid_i = 1'b0;
      mem_rdata_i  = $urandom();
      if (memDue.size() > 0 && memDue[0] <= c) begin
         mem_rvalid_i = 1'b1;
         void'(memDue.pop_front());
      end
      for (int i = 0; i < NumReq; i++) begin
         addr_i[i*AddrWidth +: AddrWidth]  = AddrWidth'($urandom());
         wdata_i[i*DataWidth +: DataWidth] = $urandom();
      end
      if (c < 80) begin
         for (int i = 0; i < NumReq; i++) begin
            cfg_weight_i[i*WeightWidth +: WeightWidth] = WeightWidth'(1);
         end
         if (c >= 40) cfg_weight_i[0 +: WeightWidth] = WeightWidth'(3);
         req_i     = '1;
         last_i    = '1;
         we_i      = '1;
         mem_gnt_i = 1'b1;
      end else begin
         if (c % 300 == 80) begin
            for (int i = 0; i < NumReq; i++) begin
               cfg_weight_i[i*WeightWidth +: WeightWidth] = WeightWidth'($urandom_range(0, 5));
            end
         end
         mem_gnt_i = ($urandom_range(99) < 75);
         for (int i = 0; i < NumReq; i++) begin
            if (remain[i] == 0 && $urandom_range(99) < 30) begin
               remain[i] = $urandom_range(1, 20);
               isWr[i]   = ($urandom_range(99) < 40);
            end
            req_i[i]  = (remain[i] > 0) && ($urandom_range(99) < 85);
            last_i[i] = (remain[i] == 1);
            we_i[i]   = isWr[i];
         end
         rst_i = (c == 2000) || ($urandom_range(299) == 0);
      end
   endtask

   initial begin
      exp_t e;
      int   own;
      bit   acc;
      repeat (3) @(posedge clk_i);
      #1;
      checkOutput("reset_gnt", 64'(gnt_o), 64'(0));
      checkOutput("reset_rvalid", 64'(rvalid_o), 64'(0));
      checkOutput("reset_busy", 64'(busy_o), 64'(0));
      checkOutput("reset_err", 64'(err_o), 64'(0));
      checkOutput("reset_mem_req", 64'(mem_req_o), 64'(0));
      checkOutput("reset_owner", 64'(owner_o), 64'(0));
      for (int c = 0; c < NumCycles; c++) begin
         applyStimulus(c);
         modelEval(e, own, acc);
         expQ.push_back(e);
         @(posedge clk_i);
         #1;
         modelUpdate(acc, own, rst_i);
         if (acc && !we_i[own]) memDue.push_back(c + $urandom_range(1, 8));
         if (acc && remain[own] > 0) remain[own]--;
      end
      @(negedge clk_i);
      #1;
      checkOutput("scoreboard_drained", 64'(expQ.size()), 64'(0));
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Monitor: compares whatever the DUT presents this cycle with the queued prediction.
   always @(negedge clk_i) begin : monitor
      exp_t e;
      if (expQ.size() > 0) begin
         e = expQ.pop_front();
         checkOutput("gnt", 64'(gnt_o), 64'(e.gnt));
         checkOutput("mem_req", 64'(mem_req_o), 64'(e.memReq));
         checkOutput("rvalid", 64'(rvalid_o), 64'(e.rvalid));
         checkOutput("err", 64'(err_o), 64'(e.err));
         checkOutput("busy", 64'(busy_o), 64'(e.busy));
         checkOutput("owner", 64'(owner_o), 64'(e.owner));
         if (e.memReq) begin
            checkOutput("mem_we", 64'(mem_we_o), 64'(e.memWe));
            checkOutput("mem_addr", 64'(mem_addr_o), 64'(e.addr));
            checkOutput("mem_wdata", 64'(mem_wdata_o), 64'(e.wdata));
         end
         if (e.rvalid != '0) begin
            checkOutput("rdata", 64'(rdata_o), 64'(e.rdata));
         end
      end
   end

endmodule

// File: doc/mem_wrr_sched.md
Name: mem_wrr_sched

Overview:
Weighted round-robin scheduler that shares one single-ported memory bank between NumReq requesters, typically several axi_to_mem front-ends feeding one SRAM macro. It grants whole bursts: once a requester wins, it owns the port until its last beat. Each requester may run up to a programmable number of consecutive bursts before priority rotates. Read responses return in order and are steered back to the issuing requester through an index FIFO.

Parameters:
NumReq, 4, number of requesters (>=2)
AddrWidth, 16, memory word address width
DataWidth, 32, data width
WeightWidth, 4, width of each per-requester weight field
MaxBurst, 16, beat limit per burst before forced release (watchdog)
MaxOutstanding, 4, response index FIFO depth (power of 2, >=2)
IdxWidth, $clog2(NumReq), derived, do not override

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  reset, synchronous, active-high
cfg_weight_i  in  NumReq*WeightWidth  bursts per turn per requester; 0 treated as 1
req_i  in  NumReq  beat request (valid)
last_i  in  NumReq  marks final beat of burst
we_i  in  NumReq  write enable per requester
addr_i  in  NumReq*AddrWidth  beat address
wdata_i  in  NumReq*DataWidth  write data
gnt_o  out  NumReq  beat accepted, one-hot0
rvalid_o  out  NumReq  read data valid for requester, one-hot0
rdata_o  out  DataWidth  read data (shared)
mem_req_o  out  1  memory request
mem_gnt_i  in  1  memory accepts beat
mem_we_o  out  1  memory write enable
mem_addr_o  out  AddrWidth  memory address
mem_wdata_o  out  DataWidth  memory write data
mem_rvalid_i  in  1  memory read data valid, in order
mem_rdata_i  in  DataWidth  memory read data
owner_o  out  IdxWidth  current or selected owner
busy_o  out  1  state is LOCK or response FIFO non-empty
err_o  out  1  one-cycle pulse on watchdog release

Behaviour:
- Beat accepted iff mem_req_o & mem_gnt_i. gnt_o[owner] = accepted. Other gnt_o bits are 0.
- Mux is combinational. mem_addr_o, mem_we_o and mem_wdata_o are taken from owner. Latency from request to memory is 0 cycles.
- State IDLE:
  - owner = first index i >= rr_q (wrapping) with req_i[i].
  - mem_req_o = |req_i & ~fifo_full.
  - Accepted beat without last: go to LOCK; beat_cnt=1.
  - Accepted beat with last: stay in IDLE; apply turn rule.
  - The same requester may be reselected on the next cycle if it still has credit.
- State LOCK:
  - owner is held in owner_q and req_i of other requesters is ignored.
  - mem_req_o = req_i[owner_q] & ~fifo_full.
  - Each accepted beat increments beat_cnt.
  - Accepted beat with last: go to IDLE; apply turn rule.
  - Accepted beat with beat_cnt==MaxBurst-1 and no last: go to IDLE; pulse err_o next cycle; rr_q=owner+1 mod NumReq; credit reset.
- Turn rule at burst end:
  - credit_q counts bursts done by owner_q.
  - If credit_q+1 >= max(weight[owner],1): rr_q <= owner+1 (wrap NumReq-1 -> 0) and credit_q <= 0.
  - Otherwise: rr_q <= owner and credit_q increments.
  - In IDLE, if no beat is accepted and req_i[rr_q] is 0 while another request exists, rr_q advances to the new owner and credit_q resets. This prevents credit hoarding by an idle requester.
- Read path:
  - An accepted beat with we=0 pushes owner into the response FIFO.
  - mem_rvalid_i pops the FIFO; rvalid_o[head]=1 and rdata_o=mem_rdata_i in the same cycle.
  - Full FIFO blocks issue for all beats (reads and writes) even if a pop happens the same cycle.
  - mem_rvalid_i while the FIFO is empty is ignored (assertion in simulation).
- Reset (rst_i=1 at clock edge):
  - State IDLE, rr_q=0, credit_q=0, beat_cnt=0, FIFO empty, err_o=0.
  - Combinational outputs then follow: gnt_o=0 and rvalid_o=0 until stimulus.
  - Reset mid-burst discards ownership and all pending responses.
- Weights are sampled each burst end; changing cfg_weight_i mid-turn takes effect at the next comparison.

Decomposition:
- Package mem_wrr_sched_pkg: state_e {IDLE, LOCK}, localparams for default weights, and helper function next_idx(rr, req) returning wrapped first-set index.
- Sub-module mem_wrr_rsp_fifo: synchronous FIFO of IdxWidth entries, depth MaxOutstanding.
  - Outputs full/empty/head.
  - Same sync active-high reset.
  - Push is ignored when full.

Test Plan:
- All weights 1; req_i=4'b1111, single-beat writes, mem_gnt_i=1 -> gnt_o rotates 0001,0010,0100,1000,0001 on consecutive cycles.
- Weight[0]=3, others 1; all requesting single-beat -> grant order 0,0,0,1,2,3,0,0,0.
- Requester 1 issues a 4-beat burst while requester 2 requests -> 4 consecutive gnt_o=0010 and no gnt to 2 until after last; then owner_o=2.
- Requester 0 issues reads without last, MaxBurst=16 -> after 16th beat, release to IDLE, err_o pulse one cycle, next grant goes to requester 1.
- Reads from requesters 3,1,2 with mem_rvalid_i delayed 5 cycles, MaxOutstanding=2 -> third read stalls (mem_req_o=0) until first rvalid; rvalid_o sequence 1000,0010,0100.
- Assert rst_i during LOCK with 2 reads outstanding -> next cycle busy_o=0, rr_q=0, and a late mem_rvalid_i produces no rvalid_o.
